// File: rtl/seq_scan_ctrl.sv
// Word-level sequencer around the serial moore1 "0110" detector: clears it,
// shifts each accepted word in MSB-first, counts hits and reports per word.

module moore1 (
    input  logic clk,
    input  logic rst,
    input  logic s_in,
    output logic s_out
);

    typedef enum logic [2:0] {S0, S1, S2, S3, S4} det_state_t;

    det_state_t state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S0;
        else     state_q <= state_d;
    end

    // Non-overlapping: after a match the trailing 0 is not reused as a new prefix.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S0:      state_d = s_in ? S0 : S1;
            S1:      state_d = s_in ? S2 : S1;
            S2:      state_d = s_in ? S3 : S1;
            S3:      state_d = s_in ? S0 : S4;
            S4:      state_d = s_in ? S0 : S1;
            default: state_d = S0;
        endcase
    end

    assign s_out = (state_q == S4);

endmodule

module seq_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             det_clr,
    output logic             det_s_in,
    input  logic             det_s_out,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_count,
    output logic             out_hit,
    input  logic             out_ready,
    output logic             busy
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, REPORT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BIT_W-1:0] bit_q,   bit_d;
    logic [CNT_W-1:0] hit_q,   hit_d;
    logic             sample;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            hit_q   <= hit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        hit_d     = hit_q;
        sample    = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b1;
        det_s_in  = 1'b0;
        out_valid = 1'b0;
        out_count = '0;
        out_hit   = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    shift_d = in_data;
                    bit_d   = BIT_LAST;
                    hit_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                det_s_in = shift_q[WIDTH-1];
                shift_d  = {shift_q[WIDTH-2:0], 1'b0};
                bit_d    = bit_q - BIT_W'(1);
                // First SHIFT cycle still shows the cleared detector, so skip it.
                sample   = (bit_q != BIT_LAST);
                if (bit_q == '0) state_d = DRAIN;
            end
            DRAIN: begin
                sample  = 1'b1;
                state_d = REPORT;
            end
            REPORT: begin
                out_valid = 1'b1;
                out_count = hit_q;
                out_hit   = (hit_q != '0);
                if (out_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (sample && det_s_out && (hit_q != '1)) hit_d = hit_q + CNT_W'(1);
    end

    assign det_clr = (state_q == CLEAR) || !rst;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: two DUTs (CNT_W=4 and saturating CNT_W=1)
// share stimulus, each driving its own moore1; a monitor checks every result.
`timescale 1ns/1ps

module tb_seq_scan_ctrl;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready_dir = 1'b1;
    logic       rnd_rdy = 1'b1;
    logic       rnd_en = 1'b0;
    logic       out_ready;

    assign out_ready = rnd_en ? rnd_rdy : out_ready_dir;

    logic       a_in_ready, a_det_clr, a_det_s_in, a_det_s_out;
    logic       a_out_valid, a_out_hit, a_busy;
    logic [3:0] a_out_count;
    logic       b_in_ready, b_det_clr, b_det_s_in, b_det_s_out;
    logic       b_out_valid, b_out_hit, b_busy;
    logic [0:0] b_out_count;

    seq_scan_ctrl #(.WIDTH(8), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_in_ready), .det_clr(a_det_clr), .det_s_in(a_det_s_in),
        .det_s_out(a_det_s_out), .out_valid(a_out_valid), .out_count(a_out_count),
        .out_hit(a_out_hit), .out_ready(out_ready), .busy(a_busy)
    );
    moore1 u_det_a (.clk(clk), .rst(a_det_clr), .s_in(a_det_s_in), .s_out(a_det_s_out));

    seq_scan_ctrl #(.WIDTH(8), .CNT_W(1)) u_dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_in_ready), .det_clr(b_det_clr), .det_s_in(b_det_s_in),
        .det_s_out(b_det_s_out), .out_valid(b_out_valid), .out_count(b_out_count),
        .out_hit(b_out_hit), .out_ready(out_ready), .busy(b_busy)
    );
    moore1 u_det_b (.clk(clk), .rst(b_det_clr), .s_in(b_det_s_in), .s_out(b_det_s_out));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Greedy leftmost non-overlapping search for 0110, MSB-first.
    function automatic int ref_hits(input logic [7:0] w);
        int n = 0;
        int i = 0;
        logic [7:0] win;
        while (i <= W - 4) begin
            win = w >> (W - 4 - i);
            if (win[3:0] == 4'b0110) begin
                n++;
                i += 4;
            end else begin
                i++;
            end
        end
        return n;
    endfunction

    typedef struct {
        int cnt;
        int acc;
    } exp_t;
    exp_t sb[$];

    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        check("busy_vs_ready", a_busy, !a_in_ready);
        check("sat_busy_vs_ready", b_busy, !b_in_ready);
        if (sb.size() == 0) begin
            check("no_pending_valid", a_out_valid, 0);
        end else if (a_out_valid) begin
            if (!prev_valid) check("latency", cyc - sb[0].acc, W + 2);
            check("out_count", a_out_count, sb[0].cnt);
            check("out_hit", a_out_hit, sb[0].cnt != 0);
            check("sat_valid", b_out_valid, 1);
            check("sat_count", b_out_count, (sb[0].cnt > 1) ? 1 : sb[0].cnt);
            check("sat_hit", b_out_hit, sb[0].cnt != 0);
            check("in_ready_in_report", a_in_ready, 0);
            if (out_ready) void'(sb.pop_front());
        end
        if (!a_out_valid) begin
            check("idle_count", a_out_count, 0);
            check("idle_hit", a_out_hit, 0);
            check("sat_valid_idle", b_out_valid, 0);
        end
        prev_valid = a_out_valid;
    end

    task automatic send_word(input logic [7:0] d, input int exp_cnt, output int acc);
        int n = 0;
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!a_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!a_in_ready) begin
            check("accept_timeout", a_in_ready, 1);
            in_valid = 1'b0;
            acc = cyc;
            return;
        end
        @(posedge clk);
        #1;
        acc   = cyc;
        e.cnt = (exp_cnt < 0) ? ref_hits(d) : exp_cnt;
        e.acc = acc;
        sb.push_back(e);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, rel, n, pos;
        logic [7:0] pat, d;

        #1;
        check("rst_in_ready", a_in_ready, 1);
        check("rst_busy", a_busy, 0);
        check("rst_det_clr", a_det_clr, 1);
        check("rst_det_s_in", a_det_s_in, 0);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_count", a_out_count, 0);
        check("rst_out_hit", a_out_hit, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("det_clr_released", a_det_clr, 0);

        pat = 8'b0110_0110;
        send_word(pat, 2, a0);
        check("clear_det_clr", a_det_clr, 1);
        check("clear_s_in", a_det_s_in, 0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check("shift_bit", a_det_s_in, pat[7 - k]);
            check("shift_det_clr", a_det_clr, 0);
        end
        @(posedge clk);
        #1;
        check("drain_s_in", a_det_s_in, 0);
        wait_drain();

        send_word(8'b0011_0110, 1, a0);
        send_word(8'h00, 0, a1);
        send_word(8'b0110_1100, 1, a2);
        check("accept_period_1", a1 - a0, W + 4);
        check("accept_period_2", a2 - a1, W + 4);
        wait_drain();

        out_ready_dir = 1'b0;
        send_word(8'b1011_0110, 1, a0);
        in_valid = 1'b1;
        in_data  = 8'b0110_0110;
        n = 0;
        while (!a_out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", a_out_valid, 1);
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", a_in_ready, 0);
            check("bp_valid_held", a_out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready_dir = 1'b1;
        rel = cyc;
        send_word(8'b0110_0110, 2, a1);
        check("release_to_accept", a1 - rel, 2);
        wait_drain();

        send_word(8'b0110_0110, 2, a0);
        repeat (4) @(posedge clk);
        #1;
        check("mid_shift_busy", a_busy, 1);
        rst = 1'b0;
        void'(sb.pop_back());
        #1;
        check("mid_rst_in_ready", a_in_ready, 1);
        check("mid_rst_busy", a_busy, 0);
        check("mid_rst_det_clr", a_det_clr, 1);
        check("mid_rst_det_s_in", a_det_s_in, 0);
        check("mid_rst_out_valid", a_out_valid, 0);
        check("mid_rst_out_count", a_out_count, 0);
        check("mid_rst_out_hit", a_out_hit, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("post_rst_det_clr", a_det_clr, 0);
        repeat (15) @(posedge clk);
        #1;
        send_word(8'b0110_0110, 2, a0);
        wait_drain();

        rnd_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                pos = $urandom_range(0, 4);
                d[(7 - pos) -: 4] = 4'b0110;
            end
            send_word(d, -1, a0);
        end
        wait_drain();
        rnd_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Sequencing controller for the team's serial Moore pattern detector (moore1, non-overlapping "0110"). It accepts parallel words over a valid/ready handshake, clears the detector, and shifts each word into it MSB-first. It counts detector hits over the word and returns a per-word result over a second valid/ready handshake. It sits between a parallel producer and one moore1 instance, so the serial detector can be used as a word-level resource.

## Interface
Parameters:
- WIDTH, 8, bits per input word; must be ≥ 4.
- CNT_W, 4, hit-counter width; must satisfy 2^CNT_W − 1 ≥ WIDTH/4.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  producer has a word.
- in_data  in  WIDTH  word to scan; bit WIDTH-1 is shifted first.
- in_ready  out  1  controller can accept a word.
- det_clr  out  1  active-high clear to detector rst.
- det_s_in  out  1  serial bit to detector s_in.
- det_s_out  in  1  detector s_out (Moore output).
- out_valid  out  1  result available.
- out_count  out  CNT_W  number of detections in the word.
- out_hit  out  1  out_count != 0.
- out_ready  in  1  consumer takes the result.
- busy  out  1  controller is not in IDLE.

## Operation
FSM states are IDLE, CLEAR, SHIFT, DRAIN and REPORT. A shift register holds the word, a bit counter is log2(WIDTH) wide, and a hit counter is CNT_W wide.

- **IDLE**
  - in_ready=1.
  - On in_valid && in_ready: latch in_data, set bit counter to WIDTH-1, zero the hit counter, go to CLEAR.
- **CLEAR** (1 cycle)
  - det_clr=1, det_s_in=0.
  - Go to SHIFT.
- **SHIFT** (WIDTH cycles)
  - det_s_in = shift_reg[WIDTH-1]. The register shifts left and the bit counter decrements each cycle.
  - When the bit counter is 0, go to DRAIN.
- **DRAIN** (1 cycle)
  - det_s_in=0.
  - Go to REPORT.
- **REPORT**
  - out_valid=1; out_count and out_hit are held stable.
  - On out_ready, go to IDLE.

Hit sampling:
- det_s_out is sampled in SHIFT cycles 2..WIDTH and in the DRAIN cycle, giving WIDTH samples. Each sample reflects the detector state after bits 1..WIDTH.
- The first SHIFT cycle is not sampled; it reflects the cleared detector.
- Each sampled 1 increments the hit counter. The counter saturates at 2^CNT_W − 1 and never wraps.

Output rules:
- det_clr = (state==CLEAR) || !rst, so the detector is held clear during controller reset.
- in_ready=0 and busy=1 in every state except IDLE.
- out_count and out_hit are 0 outside REPORT.

## Timing
Reset values, immediate on rst low:
- state=IDLE.
- in_ready=1, busy=0, det_clr=1 (while rst low), det_s_in=0.
- out_valid=0, out_count=0, out_hit=0.

Latency and throughput:
- The accept edge is E0. out_valid rises after edge E0+WIDTH+2, i.e. 10 cycles for WIDTH=8.
- Minimum period between accepts is WIDTH+4 cycles, i.e. 12 for WIDTH=8. There is at least one IDLE cycle between REPORT and the next accept.

Handshakes:
- in_valid outside IDLE is ignored; the producer must hold the word.
- in_data is sampled only on the accept edge.
- out_ready outside REPORT has no effect.
- If out_ready is high on the first REPORT cycle, out_valid lasts exactly 1 cycle.
- REPORT holds indefinitely while out_ready=0, with outputs stable.

Reset mid-operation (any state):
- Return to IDLE and discard the word; no out_valid is produced.
- After rst deasserts, the next accept behaves like the first word after reset.

## Test plan
The bench connects a moore1 instance as the detector, with `det_clr → rst`, `det_s_in → s_in`, and `s_out → det_s_out`.

- **Two matches:** WIDTH=8, in_data=8'b0110_0110, out_ready=1.
  - out_valid exactly 10 cycles after accept.
  - out_count=2, out_hit=1.
  - det_s_in sequence 0,1,1,0,0,1,1,0.
- **Single and zero matches:** in_data=8'b0011_0110 → out_count=1. in_data=8'h00 → out_count=0, out_hit=0.
- **Non-overlap check:** in_data=8'b0110_1100 → out_count=1. The controller reports exactly what the detector produces; no extra count is allowed.
- **Backpressure:** out_ready=0 for 5 cycles in REPORT.
  - out_valid, out_count and out_hit stay stable.
  - in_ready=0 and a new in_valid is not accepted.
  - Release out_ready; the next word is accepted no earlier than 1 cycle later.
  - Back-to-back words have an accept period of 12 cycles.
- **Reset mid-SHIFT:** drop rst at the 4th SHIFT cycle.
  - All outputs go to reset values immediately; det_clr=1.
  - No out_valid appears.
  - After release, word 8'b0110_0110 gives out_count=2.
- **Saturation:** CNT_W=1, WIDTH=8, in_data=8'b0110_0110 → out_count=1 (saturated), out_hit=1.
